ble_packet_tx: RTL

BLE_PACKET_TX -- requirements
Module: ble_packet_tx

---
 rtl/ble_packet_tx.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ble_packet_tx.sv
// ----------------------------------------------------------------------------
// ble_packet_tx
//
// Serialises one Bluetooth LE packet as a stream of symbols:
//    preamble -> access address -> PDU bytes -> CRC-24
// PDU and CRC bits are whitened by a 7-bit LFSR seeded from the channel
// index; the CRC is accumulated over the unwhitened PDU bits. Each symbol is
// held on 'value' for CLKS_PER_SYM clock cycles and announced by a one-cycle
// 'update' strobe. PDU bytes arrive through a one-byte prefetch buffer with a
// valid/ready handshake; if a byte is not available when it must go on air,
// the packet is aborted with an 'underrun' pulse.
//
// Ports
//    clk        : clock, everything on the rising edge
//    rst        : synchronous active-high reset
//    start      : one-cycle transmit request (ignored while busy)
//    acc_addr   : access address, latched on an accepted start
//    channel    : whitening channel index, latched on an accepted start
//    pdu_len    : PDU length in bytes (0..39), latched on an accepted start
//    byte_in    : next PDU byte
//    byte_valid : byte_in is valid
//    byte_ready : block accepts byte_in this cycle
//    update     : strobe marking a new symbol on value
//    value      : transmitted symbol bit
//    busy       : packet in progress
//    done       : one-cycle pulse at normal packet end
//    underrun   : one-cycle pulse when the packet is aborted for lack of data
// ----------------------------------------------------------------------------
module ble_packet_tx #(
   parameter int          CLKS_PER_SYM = 16,
   parameter int          PREAMBLE_LEN = 8,
   parameter int          ACC_ADDR_LEN = 32,
   parameter logic [23:0] CRC_POLY     = 24'h00065B,
   parameter logic [23:0] CRC_INIT     = 24'h555555
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] acc_addr,
   input  logic [5:0]  channel,
   input  logic [5:0]  pdu_len,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        update,
   output logic        value,
   output logic        busy,
   output logic        done,
   output logic        underrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_ACCESS,
      S_PDU,
      S_CRC
   } state_t;

   localparam int          CW       = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;
   localparam logic [CW-1:0] SYM_LAST = CW'(CLKS_PER_SYM - 1);
   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  ACC_LAST = 8'(ACC_ADDR_LEN - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] sym_cnt_q, sym_cnt_d;
   logic [7:0]    bit_cnt_q, bit_cnt_d;
   logic [31:0]   acc_sh_q, acc_sh_d;
   logic [5:0]    len_q, len_d;
   logic [23:0]   crc_q, crc_d;
   logic [6:0]    wht_q, wht_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    buf_q, buf_d;
   logic          buf_full_q, buf_full_d;
   logic [5:0]    fetch_cnt_q, fetch_cnt_d;
   logic [5:0]    byte_idx_q, byte_idx_d;
   logic          value_q, value_d;
   logic          update_q, update_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          underrun_q, underrun_d;

   logic          go_byte;
   logic          go_crc;
   logic          pdu_emit;
   logic          pdu_bit;

   // CRC-24 step on one unwhitened PDU bit.
   function automatic logic [23:0] crc_step(input logic [23:0] c, input logic d);
      logic fb;
      fb = c[23] ^ d;
      crc_step = {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
   endfunction

   // Whitening LFSR step: w0<=w6, w4<=w3^w6, other bits shift up by one.
   function automatic logic [6:0] wht_step(input logic [6:0] w);
      wht_step = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
   endfunction

   // Prefetch is open during the over-the-air part of the packet whenever the
   // single buffer slot is free and bytes are still owed by the source.
   assign byte_ready = ((state_q == S_PREAMBLE) || (state_q == S_ACCESS) || (state_q == S_PDU))
                       && !buf_full_q && (fetch_cnt_q < len_q);

   // Next-state logic. Each symbol boundary (counter at its last value) picks
   // the next bit of the current field or moves on to the next field. The
   // first bit of every PDU byte must come out of the prefetch buffer; an
   // empty buffer at that point aborts the packet instead of issuing a symbol.
   always_comb begin
      state_d     = state_q;
      sym_cnt_d   = sym_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      acc_sh_d    = acc_sh_q;
      len_d       = len_q;
      crc_d       = crc_q;
      wht_d       = wht_q;
      shift_d     = shift_q;
      buf_d       = buf_q;
      buf_full_d  = buf_full_q;
      fetch_cnt_d = fetch_cnt_q;
      byte_idx_d  = byte_idx_q;
      value_d     = value_q;
      busy_d      = busy_q;
      update_d    = 1'b0;
      done_d      = 1'b0;
      underrun_d  = 1'b0;
      go_byte     = 1'b0;
      go_crc      = 1'b0;
      pdu_emit    = 1'b0;
      pdu_bit     = 1'b0;

      if (byte_valid && byte_ready) begin
         buf_d       = byte_in;
         buf_full_d  = 1'b1;
         fetch_cnt_d = fetch_cnt_q + 6'd1;
      end

      case (state_q)
         S_IDLE: begin
            value_d = 1'b0;
            busy_d  = 1'b0;
            if (start) begin
               state_d     = S_PREAMBLE;
               acc_sh_d    = acc_addr;
               len_d       = pdu_len;
               crc_d       = CRC_INIT;
               wht_d       = {channel[0], channel[1], channel[2], channel[3],
                              channel[4], channel[5], 1'b1};
               buf_full_d  = 1'b0;
               fetch_cnt_d = '0;
               byte_idx_d  = '0;
               bit_cnt_d   = '0;
               sym_cnt_d   = '0;
               value_d     = acc_addr[0];
               update_d    = 1'b1;
               busy_d      = 1'b1;
            end
         end
         default: begin
            if (sym_cnt_q != SYM_LAST) begin
               sym_cnt_d = sym_cnt_q + CW'(1);
            end else begin
               sym_cnt_d = '0;
               update_d  = 1'b1;
               case (state_q)
                  S_PREAMBLE: begin
                     if (bit_cnt_q != PRE_LAST) begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        value_d   = acc_sh_q[0] ^ bit_cnt_d[0];
                     end else begin
                        state_d   = S_ACCESS;
                        bit_cnt_d = '0;
                        value_d   = acc_sh_q[0];
                        acc_sh_d  = acc_sh_q >> 1;
                     end
                  end
                  S_ACCESS: begin
                     if (bit_cnt_q != ACC_LAST) begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        value_d   = acc_sh_q[0];
                        acc_sh_d  = acc_sh_q >> 1;
                     end else if (len_q == 6'd0) begin
                        go_crc = 1'b1;
                     end else begin
                        go_byte = 1'b1;
                     end
                  end
                  S_PDU: begin
                     if (bit_cnt_q != 8'd7) begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        pdu_emit  = 1'b1;
                        pdu_bit   = shift_q[0];
                        shift_d   = shift_q >> 1;
                     end else if (byte_idx_q == len_q - 6'd1) begin
                        go_crc = 1'b1;
                     end else begin
                        byte_idx_d = byte_idx_q + 6'd1;
                        go_byte    = 1'b1;
                     end
                  end
                  S_CRC: begin
                     if (bit_cnt_q != 8'd23) begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        value_d   = crc_q[23] ^ wht_q[6];
                        crc_d     = crc_q << 1;
                        wht_d     = wht_step(wht_q);
                     end else begin
                        state_d  = S_IDLE;
                        update_d = 1'b0;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        value_d  = 1'b0;
                     end
                  end
                  default: ;
               endcase

               // CRC goes out MSB first through the whitener; shifting the
               // register left keeps the next bit in position 23.
               if (go_crc) begin
                  state_d   = S_CRC;
                  bit_cnt_d = '0;
                  value_d   = crc_q[23] ^ wht_q[6];
                  crc_d     = crc_q << 1;
                  wht_d     = wht_step(wht_q);
               end

               if (go_byte) begin
                  if (buf_full_q) begin
                     state_d    = S_PDU;
                     bit_cnt_d  = '0;
                     buf_full_d = 1'b0;
                     pdu_emit   = 1'b1;
                     pdu_bit    = buf_q[0];
                     shift_d    = {1'b0, buf_q[7:1]};
                  end else begin
                     state_d    = S_IDLE;
                     update_d   = 1'b0;
                     underrun_d = 1'b1;
                     busy_d     = 1'b0;
                     value_d    = 1'b0;
                  end
               end

               // The CRC sees the raw PDU bit; only the line value is whitened.
               if (pdu_emit) begin
                  value_d = pdu_bit ^ wht_q[6];
                  crc_d   = crc_step(crc_q, pdu_bit);
                  wht_d   = wht_step(wht_q);
               end
            end
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sym_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         acc_sh_q    <= '0;
         len_q       <= '0;
         crc_q       <= '0;
         wht_q       <= '0;
         shift_q     <= '0;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         fetch_cnt_q <= '0;
         byte_idx_q  <= '0;
         value_q     <= 1'b0;
         update_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sym_cnt_q   <= sym_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         acc_sh_q    <= acc_sh_d;
         len_q       <= len_d;
         crc_q       <= crc_d;
         wht_q       <= wht_d;
         shift_q     <= shift_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         fetch_cnt_q <= fetch_cnt_d;
         byte_idx_q  <= byte_idx_d;
         value_q     <= value_d;
         update_q    <= update_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         underrun_q  <= underrun_d;
      end
   end

   assign update   = update_q;
   assign value    = value_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign underrun = underrun_q;

endmodule
